// File: rtl/lev_pkg.sv
// Shared constants, command codes and parser state encoding for the
// levitation transducer command controller.
package lev_pkg;
  localparam int ARRAY_N_DEF = 8;
  localparam int WIN_N_DEF   = 4;

  localparam logic [7:0] SOF = 8'hFF;
  localparam logic [7:0] EOF = 8'h3C;

  localparam logic [7:0] CMD_LEFT  = 8'h41;  // 'A' x-1
  localparam logic [7:0] CMD_RIGHT = 8'h44;  // 'D' x+1
  localparam logic [7:0] CMD_FWD   = 8'h57;  // 'W' y-1
  localparam logic [7:0] CMD_BACK  = 8'h53;  // 'S' y+1

  typedef enum logic [1:0] {IDLE, GOT_SOF, GOT_CMD, GOT_PH} parser_state_e;
endpackage

// File: rtl/lev_frame_parser.sv
// Byte-level parser for the {SOF, CMD, PHASE, EOF} host frame with an
// inter-byte timeout that discards stalled partial frames.
module lev_frame_parser import lev_pkg::*; #(
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       frame_ok_o,
  output logic [7:0] cmd_o,
  output logic [7:0] phase_o,
  output logic       err_o,
  output logic       busy_o
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  parser_state_e    state_q, state_d;
  logic [7:0]       cmd_q, cmd_d, phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  // Fires on the TIMEOUT_CYC-th consecutive idle cycle inside a frame.
  assign timeout = (state_q != IDLE) && !rx_valid_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    phase_d    = phase_q;
    frame_ok_o = 1'b0;
    err_o      = 1'b0;
    cnt_d      = '0;
    if (state_q != IDLE && !rx_valid_i) cnt_d = cnt_q + 1'b1;
    if (timeout) begin
      state_d = IDLE;
      err_o   = 1'b1;
      cnt_d   = '0;
    end else if (rx_valid_i) begin
      unique case (state_q)
        IDLE:    if (rx_data_i == SOF) state_d = GOT_SOF;
        GOT_SOF: begin cmd_d   = rx_data_i; state_d = GOT_CMD; end
        GOT_CMD: begin phase_d = rx_data_i; state_d = GOT_PH;  end
        GOT_PH: begin
          if (rx_data_i == EOF) begin
            frame_ok_o = 1'b1;
            state_d    = IDLE;
          end else begin
            err_o   = 1'b1;
            state_d = (rx_data_i == SOF) ? GOT_SOF : IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_o   = cmd_q;
  assign phase_o = phase_q;
  assign busy_o  = (state_q != IDLE);
endmodule

// File: rtl/levitation_cmd_ctrl.sv
// Window/phase command controller: accumulates host moves into a pending
// update and commits it atomically on a waveform-period boundary.
module levitation_cmd_ctrl import lev_pkg::*; #(
  parameter int ARRAY_N     = ARRAY_N_DEF,
  parameter int WIN_N       = WIN_N_DEF,
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int PHASE_SHL   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  input  logic                         period_tick,
  output logic [$clog2(ARRAY_N)-1:0]   win_x,
  output logic [$clog2(ARRAY_N)-1:0]   win_y,
  output logic [8+PHASE_SHL-1:0]       delay,
  output logic [ARRAY_N*ARRAY_N-1:0]   en_mask,
  output logic                         cfg_upd,
  output logic                         busy,
  output logic [7:0]                   err_cnt
);
  localparam int POS_W   = $clog2(ARRAY_N);
  localparam int DLY_W   = 8 + PHASE_SHL;
  localparam int MASK_W  = ARRAY_N * ARRAY_N;
  localparam int MAX_ORG = ARRAY_N - WIN_N;
  localparam int CENTER  = MAX_ORG / 2;

  function automatic logic [MASK_W-1:0] win_mask(input logic [POS_W-1:0] x,
                                                 input logic [POS_W-1:0] y);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int r = 0; r < ARRAY_N; r++)
      for (int c = 0; c < ARRAY_N; c++)
        m[r*ARRAY_N+c] = (r >= int'(y)) && (r < int'(y) + WIN_N) &&
                         (c >= int'(x)) && (c < int'(x) + WIN_N);
    return m;
  endfunction

  logic             frame_ok, perr;
  logic [7:0]       cmd, phase;
  logic [POS_W-1:0] win_x_q, win_y_q, pend_x_q, pend_y_q;
  logic [POS_W-1:0] base_x, base_y, nx_d, ny_d;
  logic [DLY_W-1:0] delay_q, pend_dly_q;
  logic [MASK_W-1:0] en_mask_q;
  logic             pend_vld_q, cfg_upd_q, commit;
  logic [7:0]       err_cnt_q;

  lev_frame_parser #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_parser (
    .clk        (clk),
    .rst        (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .frame_ok_o (frame_ok),
    .cmd_o      (cmd),
    .phase_o    (phase),
    .err_o      (perr),
    .busy_o     (busy)
  );

  // Only an already-registered pending update can commit, so an EOF landing
  // on the tick cycle waits for the next period.
  assign commit = period_tick && pend_vld_q;

  always_comb begin
    base_x = pend_vld_q ? pend_x_q : win_x_q;
    base_y = pend_vld_q ? pend_y_q : win_y_q;
    nx_d   = base_x;
    ny_d   = base_y;
    case (cmd)
      CMD_LEFT:  if (base_x != '0)            nx_d = base_x - 1'b1;
      CMD_RIGHT: if (int'(base_x) < MAX_ORG)  nx_d = base_x + 1'b1;
      CMD_FWD:   if (base_y != '0)            ny_d = base_y - 1'b1;
      CMD_BACK:  if (int'(base_y) < MAX_ORG)  ny_d = base_y + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_x_q    <= POS_W'(CENTER);
      win_y_q    <= POS_W'(CENTER);
      delay_q    <= '0;
      en_mask_q  <= win_mask(POS_W'(CENTER), POS_W'(CENTER));
      cfg_upd_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      pend_dly_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      cfg_upd_q <= commit;
      if (commit) begin
        win_x_q   <= pend_x_q;
        win_y_q   <= pend_y_q;
        delay_q   <= pend_dly_q;
        en_mask_q <= win_mask(pend_x_q, pend_y_q);
      end
      if (frame_ok) begin
        pend_vld_q <= 1'b1;
        pend_x_q   <= nx_d;
        pend_y_q   <= ny_d;
        pend_dly_q <= DLY_W'(phase) << PHASE_SHL;
      end else if (commit) begin
        pend_vld_q <= 1'b0;
      end
      if (perr && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign win_x   = win_x_q;
  assign win_y   = win_y_q;
  assign delay   = delay_q;
  assign en_mask = en_mask_q;
  assign cfg_upd = cfg_upd_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: doc/levitation_cmd_ctrl.md
Name: levitation_cmd_ctrl

Overview:
- Controls the 8x8 ultrasonic transducer array.
- Parses the 4-byte host command frame {SOF, CMD, PHASE, EOF} delivered by the UART receiver.
- Moves the active 4x4 transducer window with clamping and scales the phase byte to a 10-bit waveform delay.
- Commits the new window, 64-bit enable mask and delay together, only on a waveform-period boundary, so the ROM-driven drive channels never glitch mid-cycle.

Parameters:
- ARRAY_N, 8, transducers per row/column.
- WIN_N, 4, active window edge length; window origin range is 0..ARRAY_N-WIN_N.
- TIMEOUT_CYC, 2_500_000, idle clk cycles between bytes before a partial frame is discarded.
- PHASE_SHL, 2, left shift applied to the phase byte to form the delay (0..1020).

Ports:
- clk  input  1  system clock (UART receiver domain).
- rst  input  1  asynchronous active-high reset.
- rx_data  input  8  received byte, valid when rx_valid=1.
- rx_valid  input  1  single-cycle strobe, one per byte.
- period_tick  input  1  single-cycle pulse when the waveform address counter wraps 1023->0 (already synchronised to clk).
- win_x  output  3  committed window column origin.
- win_y  output  3  committed window row origin.
- delay  output  10  committed phase delay added to each ROM address.
- en_mask  output  64  bit r*8+c = 1 when element (r,c) lies inside the committed window.
- cfg_upd  output  1  one-cycle pulse in the cycle after a commit.
- busy  output  1  parser is mid-frame (drives status LED).
- err_cnt  output  8  saturating count of bad-EOF frames and timeouts.

Behaviour:
- Reset values:
  - win_x=2, win_y=2, delay=0.
  - en_mask has rows 2..5 × cols 2..5 set (0x00003C3C3C3C0000).
  - cfg_upd=0, busy=0, err_cnt=0, parser state IDLE, no pending update.
- Parser FSM: IDLE -> GOT_SOF -> GOT_CMD -> GOT_PH.
  - IDLE: byte 0xFF -> GOT_SOF; any other byte is ignored.
  - GOT_SOF: any byte is latched as cmd -> GOT_CMD.
  - GOT_CMD: any byte is latched as phase -> GOT_PH.
  - GOT_PH, byte 0x3C: frame is good -> load pending, return to IDLE.
  - GOT_PH, byte 0xFF: err_cnt+1, go to GOT_SOF (resync).
  - GOT_PH, any other byte: err_cnt+1, go to IDLE.
  - busy=1 in every state except IDLE.
- Timeout: a cycle counter clears on each rx_valid. Reaching TIMEOUT_CYC in a non-IDLE state sends the FSM to IDLE and adds 1 to err_cnt. The counter does not run in IDLE.
- Pending computation on a good frame, based on the latest pending origin if one exists, otherwise the committed origin:
  - 'A' (0x41): x-1.
  - 'D' (0x44): x+1.
  - 'W' (0x57): y-1.
  - 'S' (0x53): y+1.
  - Any other code: no move, delay still updates.
  - Results clamp to 0..ARRAY_N-WIN_N; x at 0 with 'A' stays 0, and x at 4 with 'D' stays 4.
  - Pending delay = {phase, 2'b00}.
- Commit: on the first period_tick sampled while a pending update exists, win_x, win_y, delay and en_mask update together in the next cycle, and cfg_upd pulses for that one cycle.
- Latency: EOF accepted in cycle N; a tick in cycle N+1 or later commits. A tick in the same cycle as the EOF does not commit that frame.
- Multiple good frames before a tick: moves accumulate from the latest pending origin, and the latest delay wins. Only one commit occurs.
- Parsing continues while an update is pending; commit and parser are independent.
- en_mask is registered and is always derived from the values being committed, never combinational from pending.
- err_cnt saturates at 255.
- Asserting rst mid-frame or while an update is pending discards everything and restores the reset values.

Decomposition:
- Shared package lev_pkg holds:
  - constants SOF=8'hFF, EOF=8'h3C.
  - command codes CMD_LEFT, CMD_RIGHT, CMD_FWD, CMD_BACK.
  - parser state enum {IDLE, GOT_SOF, GOT_CMD, GOT_PH}.
  - ARRAY_N/WIN_N defaults.
- One sub-module, lev_frame_parser: FSM plus timeout. Outputs frame_ok pulse with cmd/phase, and err pulse.
- Top level holds the clamp arithmetic, pending registers, commit logic and mask generation.

Test Plan:
- Reset, then idle for 10 cycles -> win_x=2, win_y=2, delay=0, en_mask=0x00003C3C3C3C0000, busy=0, err_cnt=0.
- Send FF 44 40 3C, then period_tick -> next cycle win_x=3, delay=256, en_mask cols 3..6, cfg_upd high for 1 cycle. No change occurs before the tick.
- Send FF 41 00 3C three times, then one tick -> win_x clamps at 0 (from 2), exactly one cfg_upd pulse. Repeat with 'D' ×5 -> win_x=4.
- Send FF 53 10 55 -> err_cnt=1, no pending update. Then send FF 57 10 FF 57 20 3C -> err_cnt=2 and resync. After a tick: win_y=1, delay=128.
- Send FF 44, then silence for TIMEOUT_CYC -> busy falls, err_cnt+1. A later tick produces no update.
- Send a full frame, then assert rst one cycle before the tick -> all outputs at reset values and no cfg_upd. Also drive EOF and period_tick in the same cycle -> commit waits for the next tick.
